// File: rtl/shift_reg_param.sv
// shift_reg_param: parametrised multi-mode shift register.
// Single-step shifts via shift_en, or count-driven multi-cycle shifts via
// start/shamt with a busy/done handshake. Modes: 00 logical left,
// 01 logical right, 10 arithmetic right, 11 rotate left.
// Optional feature: define SHIFT_REG_PARAM_OVF_EN to add the sticky `ovf` output.
module shift_reg_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] par_in,
    input  logic             shift_en,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
`ifdef SHIFT_REG_PARAM_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_t;

    state_t           state, state_d;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_load;
    logic             do_step;
    mode_t            step_mode;
    logic [WIDTH-1:0] step_val;
    logic             step_out;

    // A multi-cycle shift uses the mode latched at start; single steps use the live input.
    assign step_mode = (state == SHIFT) ? mode_q : mode_t'(mode);
    assign busy      = (state == SHIFT);

    // Next register value and outgoing bit for one shift step in the active mode.
    always_comb begin
        step_val = par_out;
        step_out = ser_out;
        case (step_mode)
            MODE_LSL: begin
                step_val = {par_out[WIDTH-2:0], ser_in};
                step_out = par_out[WIDTH-1];
            end
            MODE_LSR: begin
                step_val = {ser_in, par_out[WIDTH-1:1]};
                step_out = par_out[0];
            end
            MODE_ASR: begin
                step_val = {par_out[WIDTH-1], par_out[WIDTH-1:1]};
                step_out = par_out[0];
            end
            MODE_ROL: begin
                step_val = {par_out[WIDTH-2:0], par_out[WIDTH-1]};
                step_out = par_out[WIDTH-1];
            end
            default: ;
        endcase
    end

    // Next-state and datapath control; priority in IDLE is ld > start > shift_en.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned -- otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        do_load = 1'b0;
        do_step = 1'b0;
        case (state)
            IDLE: begin
                if (ld) begin
                    do_load = 1'b1;
                end else if (start) begin
                    mode_d  = mode_t'(mode);
                    cnt_d   = shamt;
                    state_d = SHIFT;
                end else if (shift_en) begin
                    do_step = 1'b1;
                end
            end
            SHIFT: begin
                if (ld) begin
                    // Abort: load wins, counter cleared, no completion pulse.
                    do_load = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    do_step = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (ld) begin
                    do_load = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched mode, shift counter and the registered completion pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= MODE_LSL;
            cnt_q  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            done   <= (state == FINISH);
        end
    end

    // Shift register contents and last bit shifted out; ld leaves ser_out unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_out <= '0;
            ser_out <= 1'b0;
        end else if (do_load) begin
            par_out <= par_in;
        end else if (do_step) begin
            par_out <= step_val;
            ser_out <= step_out;
        end
    end

`ifdef SHIFT_REG_PARAM_OVF_EN
    // Sticky overflow: a 1 leaving the top in logical-left, or a sign change in arithmetic-right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (do_load) begin
            ovf <= 1'b0;
        end else if (do_step &&
                     ((step_mode == MODE_LSL && par_out[WIDTH-1]) ||
                      (step_mode == MODE_ASR && (step_val[WIDTH-1] != par_out[WIDTH-1])))) begin
            ovf <= 1'b1;
        end
    end
`else
    // Overflow tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_shift_reg_param.sv
// Self-checking bench for shift_reg_param (WIDTH=16): directed scenarios plus
// randomized loads, single steps and multi-cycle shifts. Multi-cycle results
// are queued at start and compared by a monitor when done pulses.
module tb_shift_reg_param;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          ld;
    logic [W-1:0]  par_in;
    logic          shift_en;
    logic          start;
    logic [CW-1:0] shamt;
    logic [1:0]    mode;
    logic          ser_in;
    logic [W-1:0]  par_out;
    logic          ser_out;
    logic          busy;
    logic          done;
`ifdef SHIFT_REG_PARAM_OVF_EN
    logic          ovf;
`endif

    shift_reg_param #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .par_in   (par_in),
        .shift_en (shift_en),
        .start    (start),
        .shamt    (shamt),
        .mode     (mode),
        .ser_in   (ser_in),
        .par_out  (par_out),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
`ifdef SHIFT_REG_PARAM_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] val;
        logic         sout;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t sb[$];

    // Reference model state: register value, last bit out, sticky overflow.
    logic [W-1:0] m_val;
    logic         m_sout;
    logic         m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register value after n shifts, computed in one go with plain arithmetic.
    function automatic logic [W-1:0] ref_val(input logic [W-1:0] v, input int md, input int n,
                                             input logic fill);
        bit [63:0] mask = (64'd1 << W) - 64'd1;
        bit [63:0] x    = 64'(v);
        bit [63:0] r;
        int        k;
        case (md)
            0: r = (n >= W) ? (fill ? mask : 64'd0)
                            : ((x << n) | (fill ? ((64'd1 << n) - 64'd1) : 64'd0));
            1: r = (n >= W) ? (fill ? mask : 64'd0)
                            : ((x >> n) | (fill ? (mask & ~(mask >> n)) : 64'd0));
            2: r = (n >= W) ? (v[W-1] ? mask : 64'd0)
                            : ((x >> n) | (v[W-1] ? (mask & ~(mask >> n)) : 64'd0));
            default: begin
                k = n % W;
                r = (k == 0) ? x : ((x << k) | (x >> (W - k)));
            end
        endcase
        return r[W-1:0];
    endfunction

    // Last bit pushed out after n shifts (unchanged when n is zero).
    function automatic logic ref_sout(input logic [W-1:0] v, input int md, input int n,
                                      input logic fill, input logic prev);
        logic [W-1:0] rot;
        if (n == 0) return prev;
        case (md)
            0: return (n <= W) ? v[W-n] : fill;
            1: return (n <= W) ? v[n-1] : fill;
            2: return (n <= W) ? v[n-1] : v[W-1];
            default: begin
                rot = ref_val(v, 3, n, fill);
                return rot[0];
            end
        endcase
    endfunction

    // Whether any 1 leaves the top during n logical-left shifts.
    function automatic logic ref_ovf(input logic [W-1:0] v, input int md, input int n,
                                     input logic fill);
        int k;
        if (md != 0 || n == 0) return 1'b0;
        k = (n < W) ? n : W;
        return ((64'(v) >> (W - k)) != 64'd0) || (n > W && fill);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        ld     = 1'b1;
        par_in = v;
        tick();
        ld     = 1'b0;
        m_val  = v;
        m_ovf  = 1'b0;
        check("load_val", 64'(par_out), 64'(v));
    endtask

    task automatic do_step(input int md, input logic fill);
        mode     = 2'(md);
        ser_in   = fill;
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
        m_sout   = ref_sout(m_val, md, 1, fill, m_sout);
        m_ovf    = m_ovf | ref_ovf(m_val, md, 1, fill);
        m_val    = ref_val(m_val, md, 1, fill);
        check("step_val", 64'(par_out), 64'(m_val));
        check("step_sout", 64'(ser_out), 64'(m_sout));
        check("step_busy", 64'(busy), 64'd0);
`ifdef SHIFT_REG_PARAM_OVF_EN
        check("step_ovf", 64'(ovf), 64'(m_ovf));
`endif
    endtask

    // Multi-cycle shift; the expected result is queued for the done monitor.
    task automatic do_shift(input int n, input int md, input logic fill, input bit junk);
        exp_t e;
        int   busy_cnt;
        start  = 1'b1;
        shamt  = CW'(n);
        mode   = 2'(md);
        ser_in = fill;
        tick();
        start  = 1'b0;
        e.val  = ref_val(m_val, md, n, fill);
        e.sout = ref_sout(m_val, md, n, fill, m_sout);
        e.ovf  = m_ovf | ref_ovf(m_val, md, n, fill);
        e.due  = cyc + n + 2;
        sb.push_back(e);
        m_val  = e.val;
        m_sout = e.sout;
        m_ovf  = e.ovf;
        check("busy_after_start", 64'(busy), 64'd1);
        busy_cnt = 1;
        for (int k = 1; k <= n + 1; k++) begin
            if (junk) begin
                start    = 1'($urandom_range(0, 1));
                shift_en = 1'($urandom_range(0, 1));
                mode     = 2'($urandom_range(0, 3));
                shamt    = CW'($urandom);
            end
            tick();
            if (busy) busy_cnt++;
        end
        start    = 1'b0;
        shift_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check("busy_cycles", 64'(busy_cnt), 64'(n + 1));
    endtask

    // Monitor: done must pulse exactly at the queued cycle with the queued result.
    initial begin
        exp_t e;
        bit   expect_done;
        forever begin
            @(negedge clk);
            expect_done = (sb.size() > 0) && (sb[0].due == cyc);
            if (done || expect_done) begin
                check("done_timing", 64'(done), 64'(expect_done));
                if (expect_done) begin
                    e = sb.pop_front();
                    check("done_val", 64'(par_out), 64'(e.val));
                    check("done_sout", 64'(ser_out), 64'(e.sout));
                    check("done_busy", 64'(busy), 64'd0);
`ifdef SHIFT_REG_PARAM_OVF_EN
                    check("done_ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        rst = 1'b0; ld = 1'b0; par_in = '0; shift_en = 1'b0; start = 1'b0;
        shamt = '0; mode = 2'b00; ser_in = 1'b0;
        m_val = '0; m_sout = 1'b0; m_ovf = 1'b0;

        // Reset state.
        #3;
        check("rst_par_out", 64'(par_out), 64'd0);
        check("rst_ser_out", 64'(ser_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        #14 rst = 1'b1;
        tick();

        // Asynchronous reset in the middle of a shift, before the next edge.
        do_load(16'hFFFF);
        start = 1'b1; shamt = CW'(10); mode = 2'b00; ser_in = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("async_rst_par_out", 64'(par_out), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_ser_out", 64'(ser_out), 64'd0);
        m_val = '0; m_sout = 1'b0; m_ovf = 1'b0;
        #2 rst = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'd0);

        // ld beats start and shift_en in the same idle cycle.
        ld = 1'b1; par_in = 16'h5A5A; start = 1'b1; shamt = CW'(3); shift_en = 1'b1;
        tick();
        ld = 1'b0; start = 1'b0; shift_en = 1'b0;
        m_val = 16'h5A5A; m_ovf = 1'b0;
        check("ld_prio_val", 64'(par_out), 64'h5A5A);
        check("ld_prio_busy", 64'(busy), 64'd0);
        tick();
        check("ld_prio_start_dropped", 64'(busy), 64'd0);

        // Single steps, legacy-compatible left shift and rotate.
        do_load(16'h8001);
        do_step(0, 1'b0);
        check("lsl_1_val", 64'(par_out), 64'h0002);
        check("lsl_1_sout", 64'(ser_out), 64'd1);
        do_load(16'h8001);
        do_step(3, 1'b0);
        check("rol_1_val", 64'(par_out), 64'h0003);

        // Arithmetic right by 4: five busy cycles, done at start+6.
        do_load(16'h8000);
        do_shift(4, 2, 1'b0, 1'b0);
        check("asr_4_val", 64'(par_out), 64'hF800);
        check("asr_4_sout", 64'(ser_out), 64'd0);

        // Zero-length shift still pulses done, data untouched.
        do_load(16'h00F0);
        do_shift(0, 0, 1'b0, 1'b0);
        check("shamt0_val", 64'(par_out), 64'h00F0);

        // Abort a logical-right shift with ld after three steps.
        do_load(16'h1234);
        start = 1'b1; shamt = CW'(8); mode = 2'b01; ser_in = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        ld = 1'b1; par_in = 16'hABCD;
        tick();
        ld = 1'b0;
        m_sout = ref_sout(m_val, 1, 3, 1'b1, m_sout);
        m_val  = 16'hABCD;
        m_ovf  = 1'b0;
        check("abort_val", 64'(par_out), 64'hABCD);
        check("abort_busy", 64'(busy), 64'd0);
        for (int k = 0; k < 12; k++) tick();
        check("abort_sout", 64'(ser_out), 64'(m_sout));
        do_step(1, 1'b1);
        do_shift(2, 3, 1'b0, 1'b0);

        // Shift amounts beyond the width saturate or wrap.
        do_load(16'hC3A5);
        do_shift(20, 3, 1'b1, 1'b1);
        do_load(16'h0F0F);
        do_shift(W + 3, 0, 1'b1, 1'b1);
        do_load(16'h9000);
        do_shift(31, 2, 1'b0, 1'b1);

`ifdef SHIFT_REG_PARAM_OVF_EN
        // Sticky overflow on the second left step, cleared by the next load.
        do_load(16'h4000);
        do_shift(2, 0, 1'b0, 1'b0);
        check("ovf_set", 64'(ovf), 64'd1);
        do_step(1, 1'b0);
        check("ovf_sticky", 64'(ovf), 64'd1);
        do_load(16'h0000);
        check("ovf_clear", 64'(ovf), 64'd0);
`endif

        // Randomized mix of loads, single steps and multi-cycle shifts.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: do_load(W'($urandom));
                1: do_step(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                default: do_shift(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                                  1'($urandom_range(0, 1)), 1'b1);
            endcase
        end

        for (int k = 0; k < 4; k++) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_param.md
Name: shift_reg_param

Overview:
Parametrised multi-mode shift register, the successor to the fixed 16/32-bit load-and-shift-left registers. It supports configurable width, four shift modes and a serial fill input. Shifts run either as single-step `shift_en` pulses or as a multi-cycle, count-driven shift with a busy/done handshake. It is used by the multiplier and divider datapaths, where a controller requests an N-position shift and waits for `done`.

Parameters:
- WIDTH, 16, register width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), width of the shift-amount and counter fields.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld  in  1  parallel load strobe.
- par_in  in  WIDTH  parallel load data.
- shift_en  in  1  single-step shift request (idle only).
- start  in  1  starts a multi-cycle shift of `shamt` positions (idle only).
- shamt  in  CNT_W  shift amount, sampled when `start` is accepted.
- mode  in  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left; sampled with `start`/`shift_en`.
- ser_in  in  1  fill bit for logical modes.
- par_out  out  WIDTH  register contents.
- ser_out  out  1  last bit shifted out (registered).
- busy  out  1  high while a multi-cycle shift is in progress.
- done  out  1  one-cycle pulse when a multi-cycle shift completes.

Behaviour:
- Reset (rst=0, asynchronous): par_out=0, ser_out=0, busy=0, done=0, counter=0, latched mode=00, state=IDLE.
- Single-step semantics, per mode:
  - 00: par_out <= {par_out[WIDTH-2:0], ser_in}; ser_out <= par_out[WIDTH-1].
  - 01: par_out <= {ser_in, par_out[WIDTH-1:1]}; ser_out <= par_out[0].
  - 10: par_out <= {par_out[WIDTH-1], par_out[WIDTH-1:1]}; ser_out <= par_out[0].
  - 11: par_out <= {par_out[WIDTH-2:0], par_out[WIDTH-1]}; ser_out <= par_out[WIDTH-1]; ser_in ignored.
- With ser_in=0 and mode=00, behaviour is identical to the earlier shiftReg blocks.
- State machine: IDLE, SHIFT, FINISH.
- IDLE, priority ld > start > shift_en:
  - ld: par_out <= par_in; ser_out unchanged.
  - start: latch mode, counter <= shamt, go to SHIFT; busy=1 from the next cycle.
  - shift_en: one step in the current mode; stay in IDLE; no done pulse.
- SHIFT:
  - counter≠0: one step per cycle using the latched mode; counter decrements.
  - counter==0: go to FINISH with no shift.
  - A shift of N takes N+1 cycles in SHIFT; done is asserted N+2 cycles after the start edge.
- FINISH: done=1 and busy=0 for exactly one cycle, then IDLE.
- shamt=0: no data change; done still pulses (two cycles after start).
- shamt>WIDTH: exactly shamt steps are executed, with no clamping. Logical results saturate to the fill pattern; rotate wraps modulo WIDTH.
- While busy:
  - start and shift_en are ignored.
  - ld aborts: par_in is loaded, state goes to IDLE, counter is cleared, done is not asserted.
  - mode and ser_in changes do not affect mode (it is latched); ser_in is sampled live each step.
- Reset mid-shift returns to reset values immediately; no done pulse follows.
- ld and start in the same idle cycle: the load wins and start is dropped.

Optional Feature:
- Macro: SHIFT_REG_PARAM_OVF_EN.
- With the macro defined:
  - Extra output port `ovf` (1 bit), sticky.
  - Set when a step in mode 00 shifts out a 1, or when a mode-10 step would change a sign bit (never, by construction).
  - Cleared by ld and by reset; not affected by rotate or logical-right shifts.
- Without the macro: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- WIDTH=16: reset low mid-operation after loading 16'hFFFF → par_out=0, busy=0, done=0 asynchronously, before the next clk edge.
- ld par_in=16'h8001, shift_en×1, mode=00, ser_in=0 → par_out=16'h0002, ser_out=1. Repeat with mode=11 → 16'h0003.
- ld 16'h8000, start shamt=4, mode=10 → busy high 5 cycles, done pulse at start+6 edges, par_out=16'hF800, ser_out=0.
- ld 16'h00F0, start shamt=0 → par_out unchanged, done pulses once, busy low on the done cycle.
- ld 16'h1234, start shamt=8, mode=01, ser_in=1; assert ld par_in=16'hABCD after 3 shift cycles → par_out=16'hABCD, no done pulse, busy=0, then start/shift_en are accepted again.
- (OVF_EN) ld 16'h4000, start shamt=2, mode=00 → ovf=1 after the second step; next ld → ovf=0.
